// File: rtl/magnitude_squared_cal.sv
// Magnitude-squared calculator: outputData = inputReal^2 + inputImag^2.
// Both squares are formed in parallel by a radix-2 shift-add multiplier, one
// bit per clock, from the absolute values of the signed I/Q samples.
// Optional build macro: MAG_SQ_EARLY_EXIT_EN -- when defined, MULT finishes as
// soon as both remaining multipliers are zero; results are identical either way.
module magnitude_squared_cal #(
    parameter int unsigned IN_WIDTH = 71
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [IN_WIDTH-1:0]     inputReal,
    input  logic [IN_WIDTH-1:0]     inputImag,
    output logic [2*IN_WIDTH-1:0]   outputData,
    output logic                    outputValid,
    output logic                    busy
);

    localparam int unsigned OutWidth = 2 * IN_WIDTH;
    localparam int unsigned CntWidth = $clog2(IN_WIDTH + 1);
    localparam logic [CntWidth-1:0] LastCount = CntWidth'(IN_WIDTH);

    typedef enum logic [1:0] {
        StIdle,
        StMult,
        StDone
    } stateT;

    stateT                 state;
    logic [OutWidth-1:0]   accumulator;
    logic [OutWidth-1:0]   multiplicandReal;
    logic [OutWidth-1:0]   multiplicandImag;
    logic [IN_WIDTH-1:0]   multiplierReal;
    logic [IN_WIDTH-1:0]   multiplierImag;
    logic [CntWidth-1:0]   iterCount;

    logic [IN_WIDTH-1:0]   absReal;
    logic [IN_WIDTH-1:0]   absImag;
    logic [OutWidth-1:0]   partialReal;
    logic [OutWidth-1:0]   partialImag;
    logic [OutWidth-1:0]   stepSum;
    logic                  lastStep;

    // Operand magnitudes; the most negative value maps to 2^(IN_WIDTH-1) unsigned.
    always_comb begin
        absReal = inputReal;
        absImag = inputImag;
        if (inputReal[IN_WIDTH-1]) begin
            absReal = ~inputReal + IN_WIDTH'(1);
        end
        if (inputImag[IN_WIDTH-1]) begin
            absImag = ~inputImag + IN_WIDTH'(1);
        end
    end

    // One shift-add step for both squares, and the decision to leave MULT.
    always_comb begin
        partialReal = '0;
        partialImag = '0;
        if (multiplierReal[0]) begin
            partialReal = multiplicandReal;
        end
        if (multiplierImag[0]) begin
            partialImag = multiplicandImag;
        end
        // The sum of two squares never exceeds 2^(OutWidth-1), so no carry is lost.
        stepSum  = accumulator + partialReal + partialImag;
        lastStep = (iterCount == LastCount);
`ifdef MAG_SQ_EARLY_EXIT_EN
        // No remaining multiplier bits means the accumulator already holds the result.
        if ((multiplierReal == '0) && (multiplierImag == '0)) begin
            lastStep = 1'b1;
        end
`endif
    end

    // Control FSM with datapath registers and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state            <= StIdle;
            accumulator      <= '0;
            multiplicandReal <= '0;
            multiplicandImag <= '0;
            multiplierReal   <= '0;
            multiplierImag   <= '0;
            iterCount        <= '0;
            outputData       <= '0;
            outputValid      <= 1'b0;
            busy             <= 1'b0;
        end else begin
            outputValid <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (enable) begin
                        multiplicandReal <= OutWidth'(absReal);
                        multiplicandImag <= OutWidth'(absImag);
                        multiplierReal   <= absReal;
                        multiplierImag   <= absImag;
                        accumulator      <= '0;
                        iterCount        <= '0;
                        busy             <= 1'b1;
                        state            <= StMult;
                    end
                end
                StMult: begin
                    if (lastStep) begin
                        outputData  <= accumulator;
                        outputValid <= 1'b1;
                        state       <= StDone;
                    end else begin
                        accumulator      <= stepSum;
                        multiplierReal   <= multiplierReal >> 1;
                        multiplierImag   <= multiplierImag >> 1;
                        multiplicandReal <= multiplicandReal << 1;
                        multiplicandImag <= multiplicandImag << 1;
                        iterCount        <= iterCount + CntWidth'(1);
                    end
                end
                StDone: begin
                    // Enable is ignored here; a new start waits for IDLE.
                    busy  <= 1'b0;
                    state <= StIdle;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_magnitude_squared_cal.sv
// Self-checking bench for magnitude_squared_cal (either MAG_SQ_EARLY_EXIT_EN build).
module tb_magnitude_squared_cal;

    localparam int W     = 71;
    localparam int OW    = 2 * W;
    localparam int Limit = 200;

    logic            clock = 1'b0;
    logic            reset;
    logic            enable;
    logic [W-1:0]    inputReal;
    logic [W-1:0]    inputImag;
    logic [OW-1:0]   outputData;
    logic            outputValid;
    logic            busy;

    int compared   = 0;
    int mismatched = 0;

    logic [OW-1:0] expQ[$];
    int            latQ[$];

    always #5 clock = ~clock;

    magnitude_squared_cal #(.IN_WIDTH(W)) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .inputReal  (inputReal),
        .inputImag  (inputImag),
        .outputData (outputData),
        .outputValid(outputValid),
        .busy       (busy)
    );

    function automatic logic [OW-1:0] magOf(input logic [W-1:0] v);
        logic signed [OW-1:0] s;
        s = {{(OW-W){v[W-1]}}, v};
        if (s < 0) s = -s;
        return s;
    endfunction

    function automatic logic [OW-1:0] refMagSq(input logic [W-1:0] re, input logic [W-1:0] im);
        logic [OW-1:0] a;
        logic [OW-1:0] b;
        a = magOf(re);
        b = magOf(im);
        return a * a + b * b;
    endfunction

    function automatic int expLatency(input logic [W-1:0] re, input logic [W-1:0] im);
`ifdef MAG_SQ_EARLY_EXIT_EN
        logic [OW-1:0] orv;
        int len;
        orv = magOf(re) | magOf(im);
        len = 0;
        for (int i = 0; i < OW; i++) if (orv[i]) len = i + 1;
        return len + 1;
`else
        return W + 1;
`endif
    endfunction

    function automatic logic [W-1:0] randFull();
        logic [95:0] t;
        t = {$urandom, $urandom, $urandom};
        return t[W-1:0];
    endfunction

    // Accept edge is "edge 0"; returns at the negedge following it.
    task automatic startOp(input logic [W-1:0] re, input logic [W-1:0] im);
        @(negedge clock);
        inputReal = re;
        inputImag = im;
        enable    = 1'b1;
        expQ.push_back(refMagSq(re, im));
        latQ.push_back(expLatency(re, im));
        @(negedge clock);
        enable    = 1'b0;
        inputReal = randFull();
        inputImag = randFull();
    endtask

    task automatic waitValid(output logic [OW-1:0] data, output int edges, output bit timedOut);
        edges = 0;
        while (outputValid !== 1'b1 && edges < Limit) begin
            @(negedge clock);
            edges++;
        end
        timedOut = (outputValid !== 1'b1);
        data     = outputData;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; inputReal = '0; inputImag = '0;
        repeat (3) @(negedge clock);
        compared++;
        if (outputData !== '0 || outputValid !== 1'b0 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_outputs: got data=%0h valid=%b busy=%b, want 0/0/0",
                     outputData, outputValid, busy);
        end
        reset = 1'b0;
        @(negedge clock);
        compared++;
        if (outputValid !== 1'b0 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL idle_after_release: got valid=%b busy=%b, want 0/0", outputValid, busy);
        end
    endtask

    task automatic test_basic();
        logic [OW-1:0] got, exp;
        int edges, lat;
        bit to;
        startOp(W'(3), -W'(4));
        compared++;
        if (busy !== 1'b1) begin
            mismatched++;
            $display("FAIL basic_busy: got %b want 1", busy);
        end
        waitValid(got, edges, to);
        exp = expQ.pop_front(); lat = latQ.pop_front();
        compared++;
        if (to || got !== exp) begin
            mismatched++;
            $display("FAIL basic_data: got %0d (timeout=%0b) want %0d", got, to, exp);
        end
        compared++;
        if (edges !== lat) begin
            mismatched++;
            $display("FAIL basic_latency: got edge %0d want edge %0d", edges, lat);
        end
        @(negedge clock);
        compared++;
        if (outputValid !== 1'b0 || busy !== 1'b0 || outputData !== exp) begin
            mismatched++;
            $display("FAIL basic_after_done: got valid=%b busy=%b data=%0d want 0/0/%0d",
                     outputValid, busy, outputData, exp);
        end
    endtask

    task automatic test_max_negative();
        logic [OW-1:0] got, exp, bit141;
        logic [W-1:0] mn;
        int edges, lat;
        bit to;
        mn = '0; mn[W-1] = 1'b1;
        bit141 = '0; bit141[OW-1] = 1'b1;
        startOp(mn, mn);
        waitValid(got, edges, to);
        exp = expQ.pop_front(); lat = latQ.pop_front();
        compared++;
        if (to || got !== bit141 || exp !== bit141) begin
            mismatched++;
            $display("FAIL max_negative_data: got %0h want %0h", got, bit141);
        end
        compared++;
        if (edges !== lat) begin
            mismatched++;
            $display("FAIL max_negative_latency: got %0d want %0d", edges, lat);
        end
    endtask

    task automatic test_small();
        logic [W-1:0] reT[3];
        logic [W-1:0] imT[3];
        logic [OW-1:0] got, exp;
        int edges, lat;
        bit to;
        reT[0] = '0;      imT[0] = '0;
        reT[1] = W'(5);   imT[1] = W'(2);
        reT[2] = -W'(1);  imT[2] = W'(0);
        for (int i = 0; i < 3; i++) begin
            startOp(reT[i], imT[i]);
            waitValid(got, edges, to);
            exp = expQ.pop_front(); lat = latQ.pop_front();
            compared++;
            if (to || got !== exp) begin
                mismatched++;
                $display("FAIL small_data[%0d]: got %0d want %0d", i, got, exp);
            end
            compared++;
            if (edges !== lat) begin
                mismatched++;
                $display("FAIL small_latency[%0d]: got %0d want %0d", i, edges, lat);
            end
        end
    endtask

    task automatic test_ignore_enable();
        logic [OW-1:0] got, exp;
        int edges, lat;
        bit to;
        startOp(W'(3), -W'(4));
        // Pulse enable with new operands while in MULT.
        enable = 1'b1; inputReal = W'(7); inputImag = W'(7);
        @(negedge clock);
        enable = 1'b0;
        waitValid(got, edges, to);
        exp = expQ.pop_front(); lat = latQ.pop_front();
        compared++;
        if (to || got !== exp) begin
            mismatched++;
            $display("FAIL ignore_mult_data: got %0d want %0d", got, exp);
        end
        compared++;
        if (edges + 1 !== lat) begin
            mismatched++;
            $display("FAIL ignore_mult_latency: got %0d want %0d", edges + 1, lat);
        end
        // Hold enable through DONE: the next start happens once back in IDLE.
        enable = 1'b1; inputReal = W'(7); inputImag = -W'(7);
        @(negedge clock);
        compared++;
        if (busy !== 1'b0 || outputValid !== 1'b0) begin
            mismatched++;
            $display("FAIL held_done_ignored: got busy=%b valid=%b want 0/0", busy, outputValid);
        end
        @(negedge clock);
        compared++;
        if (busy !== 1'b1) begin
            mismatched++;
            $display("FAIL held_restart_busy: got %b want 1", busy);
        end
        expQ.push_back(refMagSq(W'(7), -W'(7)));
        latQ.push_back(expLatency(W'(7), -W'(7)));
        enable = 1'b0;
        waitValid(got, edges, to);
        exp = expQ.pop_front(); lat = latQ.pop_front();
        compared++;
        if (to || got !== exp || edges !== lat) begin
            mismatched++;
            $display("FAIL held_restart_result: got %0d@%0d want %0d@%0d", got, edges, exp, lat);
        end
    endtask

    task automatic test_reset_abort();
        logic [OW-1:0] got, exp;
        logic [W-1:0] big;
        int edges, lat;
        bit to, sawValid;
        big = W'(5); big[W-3] = 1'b1;
        startOp(big, W'(6));
        repeat (29) @(negedge clock);
        @(posedge clock);
        #1 reset = 1'b1;
        #1;
        compared++;
        if (outputData !== '0 || outputValid !== 1'b0 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL abort_immediate: got data=%0d valid=%b busy=%b want 0/0/0",
                     outputData, outputValid, busy);
        end
        void'(expQ.pop_back());
        void'(latQ.pop_back());
        sawValid = 1'b0;
        repeat (3) begin
            @(negedge clock);
            if (outputValid !== 1'b0) sawValid = 1'b1;
        end
        reset = 1'b0;
        startOp(W'(1), W'(1));
        waitValid(got, edges, to);
        exp = expQ.pop_front(); lat = latQ.pop_front();
        compared++;
        if (sawValid) begin
            mismatched++;
            $display("FAIL abort_no_valid: got valid pulse during reset, want none");
        end
        compared++;
        if (to || got !== exp || exp !== OW'(2) || edges !== lat) begin
            mismatched++;
            $display("FAIL abort_restart: got %0d@%0d want %0d@%0d", got, edges, exp, lat);
        end
    endtask

    task automatic test_random();
        logic [OW-1:0] got, exp;
        logic [W-1:0] re, im;
        int edges, lat;
        bit to;
        for (int i = 0; i < 24; i++) begin
            re = randFull();
            im = randFull();
            if (i % 3 == 1) begin
                re = re >> $urandom_range(0, W - 1);
                im = im >> $urandom_range(0, W - 1);
                if ($urandom_range(0, 1) == 1) re = -re;
            end
            startOp(re, im);
            waitValid(got, edges, to);
            exp = expQ.pop_front(); lat = latQ.pop_front();
            compared++;
            if (to || got !== exp || edges !== lat) begin
                mismatched++;
                $display("FAIL random[%0d]: got %0h@%0d want %0h@%0d", i, got, edges, exp, lat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_max_negative();
        test_small();
        test_ignore_enable();
        test_reset_abort();
        test_random();
        @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/magnitude_squared_cal.md
MAGNITUDE_SQUARED_CAL -- requirements
Module: magnitude_squared_cal

Interface
REQ-001 Parameter: IN_WIDTH, default 71, signed input width; outputData width SHALL be 2*IN_WIDTH (default 142, the square-root stage input width).
REQ-002 Clocking and reset: one clock; reset is asynchronous and active-high.
REQ-003 clock  input  1  rising-edge system clock.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 enable  input  1  start strobe, sampled on rising edge, accepted only in IDLE.
REQ-006 inputReal  input  IN_WIDTH  two's-complement I sample.
REQ-007 inputImag  input  IN_WIDTH  two's-complement Q sample.
REQ-008 outputData  output  2*IN_WIDTH  unsigned I^2+Q^2.
REQ-009 outputValid  output  1  high for exactly one cycle when outputData is new.
REQ-010 busy  output  1  high whenever state is not IDLE.

Function
REQ-011 The FSM SHALL have states IDLE, MULT and DONE.
REQ-012 IDLE: enable=1 at an edge SHALL capture |inputReal| and |inputImag| as IN_WIDTH-bit unsigned multiplicands/multipliers, clear the accumulator and iteration counter, and enter MULT; enable=0 stays in IDLE.
REQ-013 Absolute value: -2^(IN_WIDTH-1) SHALL map to unsigned 2^(IN_WIDTH-1) without overflow.
REQ-014 MULT: each edge SHALL perform one radix-2 shift-add step for both squares in parallel (LSB of each multiplier selects add of the shifted multiplicand), then shift multipliers right and multiplicands left.
REQ-015 Accumulator SHALL be 2*IN_WIDTH bits unsigned; the maximum sum 2^(2*IN_WIDTH-1) SHALL fit with no wrap or saturation.
REQ-016 Without early exit, MULT SHALL run exactly IN_WIDTH steps, then enter DONE at the next edge; enable accepted at edge 0 gives outputValid=1 in the cycle after edge IN_WIDTH+1 (72 for the default).
REQ-017 DONE: outputData SHALL be loaded on entry, outputValid=1 for that one cycle, and the next edge SHALL return to IDLE unconditionally.
REQ-018 outputData SHALL hold its last value until the next entry into DONE.
REQ-019 enable while busy=1 (MULT or DONE) SHALL be ignored with no side effect; a new start is accepted at the first edge with the FSM in IDLE.
REQ-020 Input ports SHALL be ignored except at the accepting edge.

Reset
REQ-021 reset=1 SHALL immediately force state IDLE, outputData=0, outputValid=0, busy=0, and clear the accumulator, counter and operand registers.
REQ-022 Reset during MULT or DONE SHALL abort the operation without a valid pulse; after release the block SHALL accept enable at the first edge.

Configuration
REQ-023 Macro MAG_SQ_EARLY_EXIT_EN: when defined, in MULT, if both remaining multiplier registers are zero at an edge, that edge SHALL enter DONE instead of iterating; latency = L+1 edges, where L is the bit length of (|re| OR |im|); zero inputs give valid after edge 1.
REQ-024 When MAG_SQ_EARLY_EXIT_EN is undefined, latency SHALL be fixed per REQ-016 regardless of operand values; results SHALL be identical in both builds.

Verification
REQ-025 re=3, im=-4, enable at edge 0 (macro off) -> outputData=25, outputValid high only after edge 72, busy low after edge 73.
REQ-026 re=-2^70, im=-2^70 -> outputData=2^141 (bit 141 only set), no overflow.
REQ-027 Macro on: re=0, im=0 -> outputData=0 valid after edge 1; re=5, im=2 -> 29 valid after edge 4.
REQ-028 enable pulsed during MULT with re=7, im=7 presented -> ignored, original result (25) delivered; enable held high through DONE -> new start accepted at the edge after DONE.
REQ-029 reset asserted at edge 30 of an operation -> outputs 0 immediately, no outputValid pulse; re=1, im=1 started after release -> outputData=2.
REQ-030 Random signed I/Q at full width, both macro builds -> outputData equals reference I^2+Q^2 in all cases.
